// File: rtl/mem_stage_access_ctrl_pkg.sv
// Shared types for the MEM-stage data-memory access controller.
// FSM state encoding and request classification.
package mem_stage_access_ctrl_pkg;

  localparam int WORD_SIZE_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    RESP = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    REQ_NONE = 2'b00,
    REQ_RD   = 2'b01,
    REQ_WR   = 2'b10,
    REQ_BAD  = 2'b11
  } req_t;

  function automatic req_t classify(
    input logic rd,
    input logic wr
  );
    req_t r;
    unique case ({rd, wr})
      2'b10:   r = REQ_RD;
      2'b01:   r = REQ_WR;
      2'b11:   r = REQ_BAD;
      default: r = REQ_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts BUSY cycles without an ack; saturates at the
// abandon point instead of wrapping.
module mem_wait_timer #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != LAST)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expired = (cnt == LAST);

endmodule

// File: rtl/mem_stage_access_ctrl.sv
// MEM-stage req/ack sequencer between EX/MEM and MEM/WB.
// Stalls the front of the pipe while a data access is open.
module mem_stage_access_ctrl
  import mem_stage_access_ctrl_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEF,
  parameter int TIMEOUT   = 15,
  parameter int CNT_W     = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 mem_read_in,
  input  logic                 mem_write_in,
  input  logic [WORD_SIZE-1:0] addr_in,
  input  logic [WORD_SIZE-1:0] wdata_in,
  input  logic                 flush_in,
  output logic                 d_readM,
  output logic                 d_writeM,
  output logic [WORD_SIZE-1:0] d_address,
  output logic [WORD_SIZE-1:0] d_wdata,
  input  logic                 d_ack,
  input  logic [WORD_SIZE-1:0] d_rdata,
  output logic                 stall_out,
  output logic [WORD_SIZE-1:0] rdata_out,
  output logic                 done_out,
  output logic                 mem_err
);

  state_t state;
  req_t   req;
  logic   start;
  logic   bad;
  logic   expired;
  logic   stall_raw;

  assign req   = classify(mem_read_in, mem_write_in);
  assign start = (state == IDLE) && !flush_in &&
                 ((req == REQ_RD) || (req == REQ_WR));
  assign bad   = (state == IDLE) && !flush_in &&
                 (req == REQ_BAD);

  mem_wait_timer #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (start),
    .enable  ((state == BUSY) && !d_ack),
    .expired (expired)
  );

  always_comb begin
    stall_raw = 1'b0;
    unique case (1'b1)
      (state == IDLE): stall_raw = start;
      (state == BUSY): stall_raw = 1'b1;
      default:         stall_raw = 1'b0;
    endcase
  end

  // Held low while in reset so the hazard unit sees a quiet stage.
  assign stall_out = stall_raw && reset_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      d_readM   <= 1'b0;
      d_writeM  <= 1'b0;
      d_address <= '0;
      d_wdata   <= '0;
      rdata_out <= '0;
      done_out  <= 1'b0;
      mem_err   <= 1'b0;
    end else begin
      done_out <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            d_address <= addr_in;
            d_wdata   <= wdata_in;
            d_readM   <= (req == REQ_RD);
            d_writeM  <= (req == REQ_WR);
            state     <= BUSY;
          end else if (bad) begin
            mem_err  <= 1'b1;
            done_out <= 1'b1;
          end
        end
        BUSY: begin
          if (d_ack) begin
            if (d_readM) rdata_out <= d_rdata;
            d_readM  <= 1'b0;
            d_writeM <= 1'b0;
            done_out <= 1'b1;
            state    <= RESP;
          end else if (expired) begin
            d_readM   <= 1'b0;
            d_writeM  <= 1'b0;
            mem_err   <= 1'b1;
            rdata_out <= '1;
            done_out  <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_access_ctrl.sv
// Directed bench for mem_stage_access_ctrl.
// Inputs change 1ns after posedge; outputs checked 1ns later.
module tb_mem_stage_access_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mem_read_in;
  logic        mem_write_in;
  logic [15:0] addr_in;
  logic [15:0] wdata_in;
  logic        flush_in;
  logic        d_readM;
  logic        d_writeM;
  logic [15:0] d_address;
  logic [15:0] d_wdata;
  logic        d_ack;
  logic [15:0] d_rdata;
  logic        stall_out;
  logic [15:0] rdata_out;
  logic        done_out;
  logic        mem_err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_stage_access_ctrl dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .mem_read_in  (mem_read_in),
    .mem_write_in (mem_write_in),
    .addr_in      (addr_in),
    .wdata_in     (wdata_in),
    .flush_in     (flush_in),
    .d_readM      (d_readM),
    .d_writeM     (d_writeM),
    .d_address    (d_address),
    .d_wdata      (d_wdata),
    .d_ack        (d_ack),
    .d_rdata      (d_rdata),
    .stall_out    (stall_out),
    .rdata_out    (rdata_out),
    .done_out     (done_out),
    .mem_err      (mem_err)
  );

  task automatic check(input string tag,
                       input logic [15:0] got,
                       input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    reset_n      = 1'b0;
    mem_read_in  = 1'b0;
    mem_write_in = 1'b0;
    addr_in      = '0;
    wdata_in     = '0;
    flush_in     = 1'b0;
    d_ack        = 1'b0;
    d_rdata      = '0;
    #12;
    check("rst_rd",    16'(d_readM), 16'h0);
    check("rst_wr",    16'(d_writeM), 16'h0);
    check("rst_addr",  d_address, 16'h0);
    check("rst_wdata", d_wdata, 16'h0);
    check("rst_rdata", rdata_out, 16'h0);
    check("rst_done",  16'(done_out), 16'h0);
    check("rst_err",   16'(mem_err), 16'h0);
    check("rst_stall", 16'(stall_out), 16'h0);
    reset_n = 1'b1;
    tick();

    // Load, ack in third BUSY cycle
    mem_read_in = 1'b1;
    addr_in     = 16'h0040;
    #1;
    check("ld_stall_idle", 16'(stall_out), 16'h1);
    check("ld_rd_idle",    16'(d_readM), 16'h0);
    tick();
    check("ld_rd_b1",   16'(d_readM), 16'h1);
    check("ld_addr_b1", d_address, 16'h0040);
    check("ld_stall_b1", 16'(stall_out), 16'h1);
    check("ld_done_b1", 16'(done_out), 16'h0);
    tick();
    check("ld_rd_b2",    16'(d_readM), 16'h1);
    check("ld_stall_b2", 16'(stall_out), 16'h1);
    tick();
    d_ack   = 1'b1;
    d_rdata = 16'hBEEF;
    #1;
    check("ld_rd_b3",    16'(d_readM), 16'h1);
    check("ld_stall_b3", 16'(stall_out), 16'h1);
    tick();
    d_ack   = 1'b0;
    d_rdata = 16'h0000;
    #1;
    check("ld_rd_resp",    16'(d_readM), 16'h0);
    check("ld_stall_resp", 16'(stall_out), 16'h0);
    check("ld_done_resp",  16'(done_out), 16'h1);
    check("ld_rdata",      rdata_out, 16'hBEEF);
    check("ld_err",        16'(mem_err), 16'h0);
    tick();
    mem_read_in = 1'b0;
    #1;
    check("ld_no_restart", 16'(d_readM), 16'h0);
    check("ld_done_idle",  16'(done_out), 16'h0);

    // Store, immediate ack
    mem_write_in = 1'b1;
    addr_in      = 16'h0010;
    wdata_in     = 16'h1234;
    #1;
    check("st_stall_idle", 16'(stall_out), 16'h1);
    tick();
    check("st_wr_b1",    16'(d_writeM), 16'h1);
    check("st_rd_b1",    16'(d_readM), 16'h0);
    check("st_addr",     d_address, 16'h0010);
    check("st_wdata",    d_wdata, 16'h1234);
    d_ack   = 1'b1;
    d_rdata = 16'h7777;
    #1;
    check("st_stall_b1", 16'(stall_out), 16'h1);
    tick();
    d_ack = 1'b0;
    #1;
    check("st_wr_resp",    16'(d_writeM), 16'h0);
    check("st_stall_resp", 16'(stall_out), 16'h0);
    check("st_done",       16'(done_out), 16'h1);
    check("st_rdata_keep", rdata_out, 16'hBEEF);
    tick();
    mem_write_in = 1'b0;
    #1;
    check("st_no_restart", 16'(d_writeM), 16'h0);

    // Non-memory op
    #1;
    check("nm_stall", 16'(stall_out), 16'h0);
    tick();
    check("nm_rd", 16'(d_readM), 16'h0);
    check("nm_wr", 16'(d_writeM), 16'h0);

    // Flushed load
    mem_read_in = 1'b1;
    flush_in    = 1'b1;
    #1;
    check("fl_stall", 16'(stall_out), 16'h0);
    tick();
    check("fl_rd",   16'(d_readM), 16'h0);
    check("fl_done", 16'(done_out), 16'h0);

    // Flush outranks illegal read+write
    mem_write_in = 1'b1;
    tick();
    check("fl_bad_err", 16'(mem_err), 16'h0);
    mem_write_in = 1'b0;
    flush_in     = 1'b0;

    // Timeout: read, never acked
    tick();
    n = 0;
    while (d_readM === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    check("to_busy_cycles", 16'(n), 16'd15);
    check("to_err",    16'(mem_err), 16'h1);
    check("to_rdata",  rdata_out, 16'hFFFF);
    check("to_done",   16'(done_out), 16'h1);
    check("to_stall",  16'(stall_out), 16'h0);
    mem_read_in = 1'b0;
    tick();
    check("to_done_once", 16'(done_out), 16'h0);
    check("to_idle_rd",   16'(d_readM), 16'h0);
    check("to_err_stick", 16'(mem_err), 16'h1);

    // Reset in the middle of BUSY
    mem_read_in = 1'b1;
    addr_in     = 16'h0022;
    tick();
    check("mr_rd_busy", 16'(d_readM), 16'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mr_rd",    16'(d_readM), 16'h0);
    check("mr_addr",  d_address, 16'h0);
    check("mr_rdata", rdata_out, 16'h0);
    check("mr_err",   16'(mem_err), 16'h0);
    check("mr_stall", 16'(stall_out), 16'h0);
    check("mr_done",  16'(done_out), 16'h0);
    addr_in = 16'h0030;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("pr_stall_idle", 16'(stall_out), 16'h1);
    tick();
    check("pr_rd_b1", 16'(d_readM), 16'h1);
    check("pr_addr",  d_address, 16'h0030);
    d_ack   = 1'b1;
    d_rdata = 16'h5A5A;
    tick();
    d_ack = 1'b0;
    #1;
    check("pr_done",  16'(done_out), 16'h1);
    check("pr_rdata", rdata_out, 16'h5A5A);
    check("pr_rd",    16'(d_readM), 16'h0);
    check("pr_stall", 16'(stall_out), 16'h0);
    tick();
    mem_read_in = 1'b0;

    // Illegal read+write request
    mem_read_in  = 1'b1;
    mem_write_in = 1'b1;
    #1;
    check("il_stall_pre", 16'(stall_out), 16'h0);
    check("il_err_pre",   16'(mem_err), 16'h0);
    tick();
    check("il_err",  16'(mem_err), 16'h1);
    check("il_done", 16'(done_out), 16'h1);
    check("il_rd",   16'(d_readM), 16'h0);
    check("il_wr",   16'(d_writeM), 16'h0);
    mem_read_in  = 1'b0;
    mem_write_in = 1'b0;
    tick();
    check("il_done_off", 16'(done_out), 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
